// File: rtl/sram_mem_responder_pkg.sv
// Shared types and constants for the SRAM memory responder: FSM state encoding,
// SRAM write-mask constants and little-endian byte-lane helpers.
package sram_mem_responder_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FAULT   = 3'd1,
    RD      = 3'd2,
    RD_LAST = 3'd3,
    WR      = 3'd4,
    DONE    = 3'd5
  } mem_resp_state_t;

  localparam logic [7:0] SRAM_WEN_ALL  = 8'h00;
  localparam logic [7:0] SRAM_WEN_NONE = 8'hFF;
  localparam int         BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  // Byte i of a word lives in bits [8i+7:8i] (little-endian).
  function automatic logic [7:0] get_lane(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

  function automatic logic [31:0] set_lane(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[8*idx +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/sram_mem_responder_if.sv
// CPU-side memory handshake bundle between an initiator (master) and the
// SRAM responder (slave).
interface sram_mem_responder_if;

  // Handshake: the initiator pulls mem_ce low with mem_we/mem_addr/mem_wdata
  // stable and keeps it low until it sees mem_valid or mem_fault. The responder
  // raises mem_busy the cycle after it samples mem_ce low, then ends with
  // mem_valid (busy falls in the same cycle) or mem_fault (busy never rises).
  // Both stay asserted while mem_ce is low; mem_ce must then be seen high for
  // at least one cycle before the next request is accepted.
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_valid;
  logic        mem_fault;

  modport master (
    output mem_ce, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_busy, mem_valid, mem_fault
  );

  modport slave (
    input  mem_ce, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_busy, mem_valid, mem_fault
  );

endinterface

// File: rtl/sram_mem_responder_addr_window_chk.sv
// Combinational address-window check: offset from BASE_ADDR must fall inside
// the 2**SRAM_AW byte window and be word aligned.
module sram_mem_responder_addr_window_chk #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          SRAM_AW   = 9
) (
  input  logic [31:0]        addr,
  output logic               accept,
  output logic [SRAM_AW-3:0] word_idx
);

  logic [31:0] offset;

  // Subtraction wraps modulo 2**32, so addresses below BASE_ADDR land high.
  assign offset   = addr - BASE_ADDR;
  assign accept   = (offset[31:SRAM_AW] == '0) && (offset[1:0] == 2'b00);
  assign word_idx = offset[SRAM_AW-1:2];

endmodule

// File: rtl/sram_mem_responder.sv
// Memory responder serialising 32-bit loads/stores into four byte accesses on a
// byte-wide single-port SRAM. Define SRAM_MEM_RESPONDER_WAIT_EN to hold every
// SRAM byte access for two cycles (slow macros).
module sram_mem_responder
  import sram_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          SRAM_AW   = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_mem_responder_if.slave  mem,
  output logic                 sram_cen,
  output logic                 sram_gwen,
  output logic [7:0]           sram_wen,
  output logic [SRAM_AW-1:0]   sram_a,
  output logic [7:0]           sram_d,
  input  logic [7:0]           sram_q,
  output mem_resp_state_t      dbg_state
);

  mem_resp_state_t    state;
  logic [1:0]         cnt;
  logic [1:0]         cnt_nxt;
  logic [SRAM_AW-3:0] word_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               accept;
  logic [SRAM_AW-3:0] req_word;
  logic               step;

  sram_mem_responder_addr_window_chk #(
    .BASE_ADDR (BASE_ADDR),
    .SRAM_AW   (SRAM_AW)
  ) u_addr_chk (
    .addr     (mem.mem_addr),
    .accept   (accept),
    .word_idx (req_word)
  );

  assign cnt_nxt = cnt + 2'd1;

`ifdef SRAM_MEM_RESPONDER_WAIT_EN
  // hold_q marks the second cycle of a byte access; the FSM only advances then.
  logic hold_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= 1'b0;
    end else if (state == RD || state == WR) begin
      hold_q <= ~hold_q;
    end else begin
      hold_q <= 1'b0;
    end
  end

  assign step = hold_q;
`else
  assign step = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      word_q    <= '0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      sram_cen  <= 1'b1;
      sram_gwen <= 1'b1;
      sram_wen  <= SRAM_WEN_NONE;
      sram_a    <= '0;
      sram_d    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!mem.mem_ce) begin
            cnt     <= 2'd0;
            word_q  <= req_word;
            wdata_q <= mem.mem_wdata;
            if (!accept) begin
              state <= FAULT;
            end else begin
              sram_cen <= 1'b0;
              sram_a   <= {req_word, 2'b00};
              if (mem.mem_we) begin
                state     <= WR;
                sram_gwen <= 1'b0;
                sram_wen  <= SRAM_WEN_ALL;
                sram_d    <= get_lane(mem.mem_wdata, 2'd0);
              end else begin
                state <= RD;
              end
            end
          end
        end

        RD: begin
          if (step) begin
`ifdef SRAM_MEM_RESPONDER_WAIT_EN
            rdata_q <= set_lane(rdata_q, cnt, sram_q);
`else
            // sram_q trails the address by one cycle, so it holds byte cnt-1.
            if (cnt != 2'd0) rdata_q <= set_lane(rdata_q, cnt - 2'd1, sram_q);
`endif
            if (cnt == LAST_BYTE) begin
              state    <= RD_LAST;
              sram_cen <= 1'b1;
            end else begin
              cnt    <= cnt_nxt;
              sram_a <= {word_q, cnt_nxt};
            end
          end
        end

        RD_LAST: begin
          rdata_q <= set_lane(rdata_q, LAST_BYTE, sram_q);
          state   <= DONE;
        end

        WR: begin
          if (step) begin
            if (cnt == LAST_BYTE) begin
              state     <= DONE;
              sram_cen  <= 1'b1;
              sram_gwen <= 1'b1;
              sram_wen  <= SRAM_WEN_NONE;
            end else begin
              cnt    <= cnt_nxt;
              sram_a <= {word_q, cnt_nxt};
              sram_d <= get_lane(wdata_q, cnt_nxt);
            end
          end
        end

        DONE, FAULT: begin
          if (mem.mem_ce) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign mem.mem_busy  = (state == RD) || (state == RD_LAST) || (state == WR);
  assign mem.mem_valid = (state == DONE);
  assign mem.mem_fault = (state == FAULT);
  assign mem.mem_rdata = rdata_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: directed vector table, hand-written corner
// sequences and random traffic checked against a word-level memory model.
module tb_sram_mem_responder;
  import sram_mem_responder_pkg::*;

`ifdef SRAM_MEM_RESPONDER_WAIT_EN
  localparam int WR_BUSY = 8;
  localparam int RD_BUSY = 9;
  localparam int ACC_N   = 8;
`else
  localparam int WR_BUSY = 4;
  localparam int RD_BUSY = 5;
  localparam int ACC_N   = 4;
`endif
  localparam logic [31:0] BASE = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sram_mem_responder_if mem_if ();
  logic            sram_cen;
  logic            sram_gwen;
  logic [7:0]      sram_wen;
  logic [8:0]      sram_a;
  logic [7:0]      sram_d;
  logic [7:0]      sram_q = 8'h00;
  mem_resp_state_t dbg_state;

  sram_mem_responder #(.BASE_ADDR(BASE), .SRAM_AW(9)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem       (mem_if.slave),
    .sram_cen  (sram_cen),
    .sram_gwen (sram_gwen),
    .sram_wen  (sram_wen),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q),
    .dbg_state (dbg_state)
  );

  // ---------------- SRAM macro model ----------------
  logic [7:0] sram_mem [0:511];
  logic       init_done = 1'b0;
  int         sram_acc = 0;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 13 + 5) & 255);
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 512; i++) sram_mem[i] <= init_byte(i);
      init_done <= 1'b1;
    end else if (!sram_cen) begin
      sram_acc <= sram_acc + 1;
      if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else sram_q <= sram_mem[sram_a];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [0:127];
  logic [31:0] last_rd;
  logic [32:0] exp_q [$];
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_exec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic ef, output logic [31:0] er);
    logic [31:0] off;
    off = addr - BASE;
    ef = !((off < 32'd512) && (off % 4 == 0));
    er = last_rd;
    if (!ef) begin
      if (we) ref_mem[off / 4] = wdata;
      else begin
        er = ref_mem[off / 4];
        last_rd = er;
      end
    end
  endtask

  // ---------------- driver ----------------
  logic [31:0] r_rdata;
  logic        r_fault, r_timeout, r_hold_ok;
  int          r_busy, r_acc, r_lat;

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold);
    int cyc, acc0, acc1;
    logic done;
    @(negedge clk);
    mem_if.mem_ce = 1'b0;
    mem_if.mem_we = we;
    mem_if.mem_addr = addr;
    mem_if.mem_wdata = wdata;
    acc0 = sram_acc;
    r_busy = 0; r_fault = 1'b0; r_rdata = 32'h0; r_timeout = 1'b0; r_hold_ok = 1'b1;
    cyc = 0; done = 1'b0; r_lat = 0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (mem_if.mem_busy) r_busy++;
      if (mem_if.mem_valid || mem_if.mem_fault) begin
        done = 1'b1;
        r_fault = mem_if.mem_fault;
        r_rdata = mem_if.mem_rdata;
        r_lat = cyc;
      end
    end
    r_timeout = !done;
    r_acc = sram_acc - acc0;
    acc1 = sram_acc;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (mem_if.mem_busy || !(mem_if.mem_valid || mem_if.mem_fault)) r_hold_ok = 1'b0;
    end
    if (sram_acc != acc1) r_hold_ok = 1'b0;
    mem_if.mem_ce = 1'b1;
  endtask

  task automatic txn_checked(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int hold);
    logic ef;
    logic [31:0] er;
    logic [32:0] e;
    model_exec(we, addr, wdata, ef, er);
    exp_q.push_back({ef, er});
    do_txn(we, addr, wdata, hold);
    e = exp_q.pop_front();
    check({tag, " timeout"}, 32'(r_timeout), 32'd0);
    check({tag, " fault"}, 32'(r_fault), 32'(e[32]));
    check({tag, " busy"}, r_busy, e[32] ? 0 : (we ? WR_BUSY : RD_BUSY));
    check({tag, " sram_acc"}, r_acc, e[32] ? 0 : ACC_N);
    if (!e[32]) check({tag, " rdata"}, r_rdata, e[31:0]);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_fault;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic ef;
    logic [31:0] er;
    logic [31:0] rd;
    int busy_n, valid_n;

    mem_if.mem_ce = 1'b1;
    mem_if.mem_we = 1'b0;
    mem_if.mem_addr = 32'h0;
    mem_if.mem_wdata = 32'h0;
    last_rd = 32'h0;
    for (int i = 0; i < 512; i++) ref_mem[i / 4][8 * (i % 4) +: 8] = init_byte(i);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst busy", 32'(mem_if.mem_busy), 32'd0);
    check("rst valid", 32'(mem_if.mem_valid), 32'd0);
    check("rst fault", 32'(mem_if.mem_fault), 32'd0);
    check("rst rdata", mem_if.mem_rdata, 32'h0);
    check("rst sram_cen", 32'(sram_cen), 32'd1);
    check("rst sram_wen", 32'(sram_wen), 32'hFF);
    check("rst state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;

    // Store then load, checking the SRAM byte lanes
    txn_checked("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 0);
    check("st10 byte0", 32'(sram_mem[16]), 32'hEF);
    check("st10 byte1", 32'(sram_mem[17]), 32'hBE);
    check("st10 byte2", 32'(sram_mem[18]), 32'hAD);
    check("st10 byte3", 32'(sram_mem[19]), 32'hDE);
    txn_checked("ld10", 1'b0, 32'h10, 32'h0, 0);
    check("ld10 direct", r_rdata, 32'hDEAD_BEEF);

    // Out-of-window: fault the cycle after ce low, clears one cycle after ce high
    txn_checked("oow", 1'b0, 32'h200, 32'h0, 0);
    check("oow latency", r_lat, 1);
    @(negedge clk);
    check("oow fault clear", 32'(mem_if.mem_fault), 32'd0);

    // Misaligned then a normal aligned load
    txn_checked("mis6", 1'b0, 32'h6, 32'h0, 0);
    txn_checked("ld4", 1'b0, 32'h4, 32'h0, 0);
    check("ld4 direct", r_rdata, 32'h6053_4639);

    // Table of directed vectors
    vecs[0] = '{1'b1, 32'h0000_01FC, 32'hA5A5_5A5A, 1'b0, 32'h6053_4639};
    vecs[1] = '{1'b0, 32'h0000_01FC, 32'h0,         1'b0, 32'hA5A5_5A5A};
    vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_01FE, 32'h0,         1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'h0102_0304, 1'b0, 32'hA5A5_5A5A};
    vecs[6] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0102_0304};
    vecs[7] = '{1'b1, 32'h0000_0201, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[8] = '{1'b0, 32'h0000_01FC, 32'h0,         1'b0, 32'hA5A5_5A5A};
    vecs[9] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    for (int i = 0; i < 10; i++) begin
      txn_checked($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, 0);
      check($sformatf("vec%0d tbl fault", i), 32'(r_fault), 32'(vecs[i].exp_fault));
      if (!vecs[i].exp_fault) check($sformatf("vec%0d tbl rdata", i), r_rdata, vecs[i].exp_rdata);
    end

    // Hold ce low after valid: one transaction only, no SRAM activity
    txn_checked("hold", 1'b0, 32'h14, 32'h0, 10);
    check("hold steady", 32'(r_hold_ok), 32'd1);
    txn_checked("after hold", 1'b0, 32'h18, 32'h0, 0);

    // ce released during the read: completes, valid for exactly one cycle
    model_exec(1'b0, 32'h10, 32'h0, ef, er);
    @(negedge clk);
    mem_if.mem_ce = 1'b0;
    mem_if.mem_we = 1'b0;
    mem_if.mem_addr = 32'h10;
    @(negedge clk);
    busy_n = mem_if.mem_busy ? 1 : 0;
    mem_if.mem_ce = 1'b1;
    valid_n = 0;
    rd = 32'h0;
    repeat (20) begin
      @(negedge clk);
      if (mem_if.mem_busy) busy_n++;
      if (mem_if.mem_valid) begin
        valid_n++;
        rd = mem_if.mem_rdata;
      end
    end
    check("early rel busy", busy_n, RD_BUSY);
    check("early rel valid cycles", valid_n, 1);
    check("early rel rdata", rd, er);
    check("early rel idle", 32'(dbg_state), 32'(IDLE));

    // Asynchronous reset in the middle of a store
    @(negedge clk);
    mem_if.mem_ce = 1'b0;
    mem_if.mem_we = 1'b1;
    mem_if.mem_addr = 32'h20;
    mem_if.mem_wdata = 32'h1122_3344;
    repeat (2) @(negedge clk);
    check("midwr busy before rst", 32'(mem_if.mem_busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midwr rst busy", 32'(mem_if.mem_busy), 32'd0);
    check("midwr rst valid", 32'(mem_if.mem_valid), 32'd0);
    check("midwr rst rdata", mem_if.mem_rdata, 32'h0);
    check("midwr rst cen", 32'(sram_cen), 32'd1);
    check("midwr rst gwen", 32'(sram_gwen), 32'd1);
    check("midwr rst wen", 32'(sram_wen), 32'hFF);
    check("midwr rst a", 32'(sram_a), 32'd0);
    check("midwr rst d", 32'(sram_d), 32'd0);
    last_rd = 32'h0;
    @(negedge clk);
    mem_if.mem_ce = 1'b1;
    reset = 1'b1;
    txn_checked("post rst st", 1'b1, 32'h20, 32'hCAFE_F00D, 0);
    txn_checked("post rst ld", 1'b0, 32'h20, 32'h0, 0);

    // Random traffic against the word-level model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel <= 1) a = 32'($urandom_range(0, 127)) * 4;
      else if (sel == 2) a = 32'($urandom_range(0, 127)) * 4 + 32'($urandom_range(1, 3));
      else begin
        a = $urandom;
        if (a < 32'd512) a = a + 32'd512;
      end
      txn_checked($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
